// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions inside {N,V,Z} and the PADDSB lane width.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } alu_op_e;

    // Bit positions inside a {N,V,Z} triple
    localparam int N_IDX = 2;
    localparam int V_IDX = 1;
    localparam int Z_IDX = 0;

    // Width of one PADDSB lane
    localparam int LANE_W = 4;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath sitting between S1 and S2.
// Produces the result, its {N,V,Z}, the illegal marker and wr_nv, which
// tells the flag register whether N and V are written along with Z.
// Optional feature: define ALU_PADDSB_EN to build the PADDSB lane adder;
// without it opcode 111 is reported as illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nvz,
    output logic             illegal,
    output logic             wr_nv
);

    localparam int SH_W   = $clog2(WIDTH);
    localparam int NBYTES = WIDTH / 8;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    genvar gi;

    // Saturating add/sub: overflow is judged from the operand and raw result signs
    logic [WIDTH-1:0] add_raw;
    logic [WIDTH-1:0] sub_raw;
    logic             add_ovf;
    logic             sub_ovf;

    // Raw sums and signed overflow detection
    always_comb begin
        add_raw = a + b;
        sub_raw = a - b;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_raw[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_raw[WIDTH-1] != a[WIDTH-1]);
    end

    // Byte reduction: every byte sign-extended to WIDTH; the total always fits
    logic [WIDTH-1:0] a_byte_ext [NBYTES];
    logic [WIDTH-1:0] b_byte_ext [NBYTES];
    logic [WIDTH-1:0] red_sum;

    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign a_byte_ext[gi] = {{(WIDTH-8){a[8*gi+7]}}, a[8*gi +: 8]};
            assign b_byte_ext[gi] = {{(WIDTH-8){b[8*gi+7]}}, b[8*gi +: 8]};
        end
    endgenerate

    // Accumulate all sign-extended bytes of both operands
    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NBYTES; i++) begin
            red_sum = red_sum + a_byte_ext[i] + b_byte_ext[i];
        end
    end

    // Shifter; a left shift by WIDTH (amount 0) yields zero, so ROR of 0 is a
    logic [SH_W-1:0]  shamt;
    logic [SH_W:0]    rot_left;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] ror_res;

    // Shift and rotate results
    always_comb begin
        shamt    = b[SH_W-1:0];
        rot_left = (SH_W+1)'(WIDTH) - {1'b0, shamt};
        sll_res  = a << shamt;
        sra_res  = $signed(a) >>> shamt;
        ror_res  = (a >> shamt) | (a << rot_left);
    end

`ifdef ALU_PADDSB_EN
    localparam int LANES = WIDTH / LANE_W;
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic [WIDTH-1:0] padd_res;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W:0] lane_sum;
            assign lane_sum = {a[gi*LANE_W+LANE_W-1], a[gi*LANE_W +: LANE_W]}
                            + {b[gi*LANE_W+LANE_W-1], b[gi*LANE_W +: LANE_W]};
            assign padd_res[gi*LANE_W +: LANE_W] =
                (lane_sum[LANE_W] != lane_sum[LANE_W-1])
                    ? (lane_sum[LANE_W] ? LANE_MIN : LANE_MAX)
                    : lane_sum[LANE_W-1:0];
        end
    endgenerate
`endif

    logic [WIDTH-1:0] res;
    logic             ovf;

    // Opcode select and {N,V,Z} formation
    always_comb begin
        res     = '0;
        ovf     = 1'b0;
        wr_nv   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                res   = add_ovf ? (a[WIDTH-1] ? SAT_MIN : SAT_MAX) : add_raw;
                ovf   = add_ovf;
                wr_nv = 1'b1;
            end
            OP_SUB: begin
                res   = sub_ovf ? (a[WIDTH-1] ? SAT_MIN : SAT_MAX) : sub_raw;
                ovf   = sub_ovf;
                wr_nv = 1'b1;
            end
            OP_XOR:    res = a ^ b;
            OP_RED:    res = red_sum;
            OP_SLL:    res = sll_res;
            OP_SRA:    res = sra_res;
            OP_ROR:    res = ror_res;
            OP_PADDSB: begin
`ifdef ALU_PADDSB_EN
                res = padd_res;
`else
                illegal = 1'b1;
`endif
            end
            default:   illegal = 1'b1;
        endcase

        result = res;
        nvz    = '0;
        if (!illegal) begin
            nvz[N_IDX] = wr_nv & res[WIDTH-1];
            nvz[V_IDX] = ovf;
            nvz[Z_IDX] = (res == '0);
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline. S1 registers the accepted operands,
// S2 registers the computed result; the architectural {N,V,Z} register is
// written when S2 hands its result off.
// Optional feature: define ALU_PADDSB_EN to execute PADDSB for opcode 111
// (passed down to alu_core).
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int         WIDTH     = 16,   // multiple of 8, at least 16
    parameter logic [2:0] FLAG_INIT = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_nvz,
    output logic             out_illegal,
    output logic [2:0]       flags
);

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    alu_op_e          s1_op_q, s1_op_d;

    // S2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [2:0]       s2_nvz_q, s2_nvz_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic             s2_wr_nv_q, s2_wr_nv_d;

    // Architectural flags
    logic [2:0]       flags_q, flags_d;

    // Core outputs
    logic [WIDTH-1:0] core_result;
    logic [2:0]       core_nvz;
    logic             core_illegal;
    logic             core_wr_nv;

    logic             s1_advance;
    logic             accept;
    logic             retire;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op      (s1_op_q),
        .a       (s1_a_q),
        .b       (s1_b_q),
        .result  (core_result),
        .nvz     (core_nvz),
        .illegal (core_illegal),
        .wr_nv   (core_wr_nv)
    );

    // Handshake control: S1 moves whenever S2 is empty or draining
    always_comb begin
        s1_advance = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s1_advance;
        accept     = in_valid && in_ready;
        retire     = s2_valid_q && out_ready;
    end

    // S1 next state: load on accept, empty when its content moves on
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = alu_op_e'(in_op);
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state: capture the core output when S1 advances, else hold
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_nvz_d     = s2_nvz_q;
        s2_illegal_d = s2_illegal_q;
        s2_wr_nv_d   = s2_wr_nv_q;
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = core_result;
                s2_nvz_d     = core_nvz;
                s2_illegal_d = core_illegal;
                s2_wr_nv_d   = core_wr_nv;
            end
        end
    end

    // Flag update on retirement: ADD/SUB write all three, others only Z
    always_comb begin
        flags_d = flags_q;
        if (retire && !s2_illegal_q) begin
            if (s2_wr_nv_q) begin
                flags_d = s2_nvz_q;
            end else begin
                flags_d[Z_IDX] = s2_nvz_q[Z_IDX];
            end
        end
    end

    // State registers with asynchronous reset; in-flight work is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_ADD;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_nvz_q     <= '0;
            s2_illegal_q <= 1'b0;
            s2_wr_nv_q   <= 1'b0;
            flags_q      <= FLAG_INIT;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_nvz_q     <= s2_nvz_d;
            s2_illegal_q <= s2_illegal_d;
            s2_wr_nv_q   <= s2_wr_nv_d;
            flags_q      <= flags_d;
        end
    end

    // Output view of S2 and the flag register
    always_comb begin
        out_valid   = s2_valid_q;
        out_result  = s2_result_q;
        out_nvz     = s2_nvz_q;
        out_illegal = s2_illegal_q;
        flags       = flags_q;
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH=16): directed checks of the
// documented examples, stall/reset scenarios, then randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_alu;

    localparam int         W  = 16;
    localparam logic [2:0] FI = 3'b100;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_nvz;
    logic         out_illegal;
    logic [2:0]   flags;

    pipelined_alu #(
        .WIDTH     (W),
        .FLAG_INIT (FI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_nvz     (out_nvz),
        .out_illegal (out_illegal),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic [2:0]   nvz;
        logic         ill;
        logic         arith;
    } exp_t;

    exp_t         q[$];
    logic [2:0]   m_flags;
    int           n_vec = 0;
    int           n_err = 0;
    logic         popped;
    logic         accepted;
    logic [W-1:0] last_res;
    logic [2:0]   last_nvz;
    logic         last_ill;
    int           last_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built from integer arithmetic and per-bit rules
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   s;
        int   sh;
        int   max_v;
        int   min_v;
        logic signed [7:0] ba;
        logic signed [7:0] bb;
        logic signed [3:0] la;
        logic signed [3:0] lb;
        e     = '0;
        sh    = int'(b[$clog2(W)-1:0]);
        max_v = (1 << (W-1)) - 1;
        min_v = -(1 << (W-1));
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? ($signed(a) + $signed(b)) : ($signed(a) - $signed(b));
                e.nvz[1] = (s > max_v) || (s < min_v);
                if (s > max_v) s = max_v;
                if (s < min_v) s = min_v;
                e.res   = s[W-1:0];
                e.arith = 1'b1;
            end
            3'd2: e.res = a ^ b;
            3'd3: begin
                s = 0;
                for (int i = 0; i < W/8; i++) begin
                    ba = a[8*i +: 8];
                    bb = b[8*i +: 8];
                    s  = s + ba + bb;
                end
                e.res = s[W-1:0];
            end
            3'd4: for (int i = 0; i < W; i++) e.res[i] = (i >= sh) ? a[i-sh] : 1'b0;
            3'd5: for (int i = 0; i < W; i++) e.res[i] = (i + sh < W) ? a[i+sh] : a[W-1];
            3'd6: for (int i = 0; i < W; i++) e.res[i] = a[(i+sh) % W];
            default: begin
`ifdef ALU_PADDSB_EN
                for (int l = 0; l < W/4; l++) begin
                    la = a[4*l +: 4];
                    lb = b[4*l +: 4];
                    s  = la + lb;
                    if (s > 7)  s = 7;
                    if (s < -8) s = -8;
                    e.res[4*l +: 4] = s[3:0];
                end
`else
                e.ill = 1'b1;
`endif
            end
        endcase
        if (!e.ill) begin
            e.nvz[2] = e.arith & e.res[W-1];
            e.nvz[0] = (e.res == '0);
        end
        return e;
    endfunction

    // One clock: check flags, drive inputs, then score both handshakes
    task automatic do_cycle(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ordy);
        exp_t e;
        @(negedge clk);
        check("flags", flags, m_flags);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !(q.size() == 2 && !ordy));
        popped   = 1'b0;
        accepted = 1'b0;
        if (q.size() == 0) begin
            check("idle_valid", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
            e = q.pop_front();
            check("result", out_result, e.res);
            check("nvz", out_nvz, e.nvz);
            check("illegal", out_illegal, e.ill);
            if (!e.ill) begin
                if (e.arith) m_flags = e.nvz;
                else         m_flags[0] = e.nvz[0];
            end
            last_res = out_result;
            last_nvz = out_nvz;
            last_ill = out_illegal;
            popped   = 1'b1;
        end
        if (in_valid && in_ready) begin
            q.push_back(model(op, a, b));
            accepted = 1'b1;
        end
        $display("cyc v=%0d op=%0d a=%04h b=%04h ordy=%0d -> acc=%0d ret=%0d res=%04h nvz=%03b ill=%0d flags=%03b",
                 v, op, a, b, ordy, accepted, popped, out_result, out_nvz, out_illegal, flags);
    endtask

    // Issue one operation into an empty pipe and wait (bounded) for it
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        do_cycle(1'b1, op, a, b, 1'b1);
        last_lat = 0;
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
            if (popped) begin
                last_lat = k;
                break;
            end
        end
        check("retire_timeout", popped, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    logic [2:0]   flags_before;
    logic [W-1:0] held;
    int           acc_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        m_flags   = FI;
        popped    = 1'b0;
        accepted  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, '0);
        check("rst_out_nvz", out_nvz, '0);
        check("rst_out_illegal", out_illegal, 1'b0);
        check("rst_flags", flags, FI);
        rst = 1'b0;

        // Saturating ADD, two-cycle latency, flags next cycle
        run_op(3'd0, 16'h7FFF, 16'h0001);
        check("add_sat_res", last_res, 16'h7FFF);
        check("add_sat_nvz", last_nvz, 3'b010);
        check("latency", last_lat, 2);
        do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        check("add_flags", flags, 3'b010);

        // Saturating SUB then XOR to zero: Z only, N and V held
        run_op(3'd1, 16'h8000, 16'h0001);
        check("sub_sat_res", last_res, 16'h8000);
        check("sub_sat_nvz", last_nvz, 3'b110);
        run_op(3'd2, 16'h00FF, 16'h00FF);
        check("xor_res", last_res, 16'h0000);
        check("xor_nvz", last_nvz, 3'b001);
        do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        check("xor_flags", flags, 3'b111);

        // Shifts and rotate examples
        run_op(3'd5, 16'h8000, 16'h0004);
        check("sra_res", last_res, 16'hF800);
        run_op(3'd6, 16'h0001, 16'h0001);
        check("ror_res", last_res, 16'h8000);
        run_op(3'd4, 16'h1234, 16'h0000);
        check("sll0_res", last_res, 16'h1234);

        // Opcode 111: PADDSB when built in, illegal otherwise
        do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        flags_before = flags;
        run_op(3'd7, 16'h7777, 16'h1111);
`ifdef ALU_PADDSB_EN
        check("paddsb_res", last_res, 16'h7777);
        check("paddsb_ill", last_ill, 1'b0);
`else
        check("op7_res", last_res, 16'h0000);
        check("op7_nvz", last_nvz, 3'b000);
        check("op7_ill", last_ill, 1'b1);
        do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        check("op7_flags", flags, flags_before);
`endif

        // Back-pressure: only two accepts while stalled, result held
        acc_cnt = 0;
        held    = '0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 3'($urandom_range(0, 6)), rand_operand(), rand_operand(), 1'b0);
            if (accepted) acc_cnt++;
            if (i == 2) held = out_result;
            if (i == 3) check("stall_hold", out_result, held);
        end
        check("stall_accepts", acc_cnt, 2);
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        end
        check("stall_drain", q.size(), 0);

        // Asynchronous reset with two operations in flight
        do_cycle(1'b1, 3'd1, 16'h8000, 16'h0001, 1'b1);
        do_cycle(1'b1, 3'd0, 16'h7FFF, 16'h7FFF, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_flags", flags, FI);
        q.delete();
        m_flags = FI;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            do_cycle(($urandom % 4) != 0, 3'($urandom_range(0, 7)),
                     rand_operand(), rand_operand(), ($urandom % 4) != 0);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            do_cycle(1'b0, 3'd0, '0, '0, 1'b1);
        end
        check("final_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
